// File: rtl/mic_capture_fifo.sv
// mic_capture_fifo
//   Sound-in capture for the monitor link. An I2S stream (bclk/lrck/data),
//   asynchronous to clk, is oversampled and deframed into (L, R) frames.
//   One channel (or the signed mean of both) is encoded as 8-bit mu-law or
//   16-bit linear. Samples are packed MSB-first into 32-bit words and queued
//   in a small FIFO for the packet sender.
//
// Ports
//   clk, rst_n                : monitor clock, async active-low reset
//   record_start/record_stop  : one-clk control pulses (stop wins)
//   bclk, lrck, audio_data_in : raw I2S inputs (lrck 0 = left)
//   mode                      : 0 = mu-law (4 per word), 1 = linear (2 per word)
//   chan_sel                  : 0/3 left, 1 right, 2 signed mean
//   mic_data, mic_data_valid  : FIFO head word and its valid flag
//   mic_data_retrieved        : pop strobe
//   fifo_level                : words currently stored
//   overflow                  : sticky, a completed word was dropped
//   mic_debug                 : {mic_data_valid, record active}
module mic_capture_fifo #(
    parameter int SAMPLE_BITS     = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int START_DELAY     = 100,
    parameter int PREFILL_SILENCE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          record_start,
    input  logic                          record_stop,
    input  logic                          bclk,
    input  logic                          lrck,
    input  logic                          audio_data_in,
    input  logic                          mode,
    input  logic [1:0]                    chan_sel,
    output logic [31:0]                   mic_data,
    output logic                          mic_data_valid,
    input  logic                          mic_data_retrieved,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [1:0]                    mic_debug
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(SAMPLE_BITS + 1);
    localparam int DW = $clog2(START_DELAY + 1);
    localparam logic [BW-1:0] BITS_ALL  = BW'(SAMPLE_BITS);
    localparam logic [BW-1:0] BITS_LAST = BW'(SAMPLE_BITS - 1);
    localparam logic [DW-1:0] DLY_LAST  = DW'(START_DELAY - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;

    // 13-bit linear to mu-law: the classic biased 16-bit encoder fed with
    // the 13 significant bits, giving 0 -> 0xFF and full scale -> 0x80.
    function automatic logic [7:0] lin2mlaw(input logic [12:0] x);
        logic [15:0] s;
        logic [15:0] mag;
        logic        sgn;
        logic [2:0]  e;
        logic [3:0]  m;
        s   = {x, 3'b000};
        sgn = s[15];
        mag = sgn ? (~s + 16'd1) : s;
        if (mag > 16'd32635) mag = 16'd32635;
        mag = mag + 16'd132;
        e   = 3'd0;
        for (int i = 1; i < 8; i++) if (mag[i+7]) e = 3'(i);
        m   = 4'(mag >> ({1'b0, e} + 4'd3));
        return ~{sgn, e, m};
    endfunction

    // Signed mean: 17-bit sum, arithmetic shift right by one.
    function automatic logic [15:0] mix_lr(input logic [15:0] l, input logic [15:0] r);
        logic signed [16:0] sum;
        sum = $signed({l[15], l}) + $signed({r[15], r});
        return sum[16:1];
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] c, input logic [15:0] l,
                                         input logic [15:0] r);
        case (c)
            2'd1:    return r;
            2'd2:    return mix_lr(l, r);
            default: return l;
        endcase
    endfunction

    logic [1:0]             bclk_sync, lrck_sync, data_sync;
    logic                   bclk_prev, lrck_last;
    logic                   slot_live, slot_right, left_ok, frame_vld;
    logic [BW-1:0]          bit_cnt;
    logic [SAMPLE_BITS-1:0] shift, shift_next;
    logic [15:0]            left_smp, frame_l, frame_r, sel;
    logic                   rise, lrck_s, data_s, slot_start, shift_en, slot_done;

    state_t                 state, state_next;
    logic                   enter_active, flush;
    logic [DW-1:0]          dly_cnt;
    logic                   lin_q;
    logic [1:0]             chan_q;
    logic [1:0]             pack_idx;
    logic [31:0]            pack_sr, packed_next, push_word;
    logic                   pack_last, frame_take, push_req;
    logic [31:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [LW-1:0]          count;
    logic                   full, pop, do_push, push_drop;

    assign lrck_s     = lrck_sync[1];
    assign data_s     = data_sync[1];
    assign rise       = bclk_sync[1] & ~bclk_prev;
    // The rise that reveals an LRCK change carries the I2S one-bit delay.
    assign slot_start = rise && (lrck_s != lrck_last);
    assign shift_en   = rise && (lrck_s == lrck_last) && slot_live && (bit_cnt < BITS_ALL);
    assign slot_done  = shift_en && (bit_cnt == BITS_LAST);
    assign shift_next = {shift[SAMPLE_BITS-2:0], data_s};

    // ---- Front end: synchronise, detect BCLK rises, deframe ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync  <= '0;
            lrck_sync  <= '0;
            data_sync  <= '0;
            bclk_prev  <= 1'b0;
            lrck_last  <= 1'b0;
            slot_live  <= 1'b0;
            slot_right <= 1'b0;
            left_ok    <= 1'b0;
            frame_vld  <= 1'b0;
            bit_cnt    <= '0;
            shift      <= '0;
            left_smp   <= '0;
            frame_l    <= '0;
            frame_r    <= '0;
        end else begin
            bclk_sync <= {bclk_sync[0], bclk};
            lrck_sync <= {lrck_sync[0], lrck};
            data_sync <= {data_sync[0], audio_data_in};
            bclk_prev <= bclk_sync[1];
            frame_vld <= 1'b0;
            if (slot_start) begin
                lrck_last  <= lrck_s;
                slot_live  <= 1'b1;
                slot_right <= lrck_s;
                bit_cnt    <= '0;
                if (!lrck_s) left_ok <= 1'b0;
            end else if (shift_en) begin
                shift   <= shift_next;
                bit_cnt <= bit_cnt + BW'(1);
                if (slot_done) begin
                    if (!slot_right) begin
                        left_ok  <= 1'b1;
                        left_smp <= shift_next[SAMPLE_BITS-1 -: 16];
                    end else if (left_ok) begin
                        frame_vld <= 1'b1;
                        frame_l   <= left_smp;
                        frame_r   <= shift_next[SAMPLE_BITS-1 -: 16];
                        left_ok   <= 1'b0;
                    end
                end
            end
        end
    end

    // ---- Record FSM next state ----
    always_comb begin
        state_next   = state;
        enter_active = 1'b0;
        case (state)
            IDLE:    if (record_start && !record_stop) state_next = DELAY;
            DELAY: begin
                if (record_stop)              state_next = IDLE;
                else if (record_start)        state_next = DELAY;
                else if (dly_cnt == DLY_LAST) begin
                    state_next   = ACTIVE;
                    enter_active = 1'b1;
                end
            end
            ACTIVE: begin
                if (record_stop)       state_next = IDLE;
                else if (record_start) state_next = DELAY;
            end
            default: state_next = IDLE;
        endcase
    end

    // A start in any state flushes too: in IDLE the FIFO is already empty.
    assign flush       = record_stop | record_start;
    assign sel         = pick(chan_q, frame_l, frame_r);
    assign packed_next = lin_q ? {pack_sr[15:0], sel} : {pack_sr[23:0], lin2mlaw(sel[15:3])};
    assign pack_last   = lin_q ? (pack_idx == 2'd1) : (pack_idx == 2'd3);
    assign frame_take  = frame_vld && (state == ACTIVE) && !flush;

    assign full           = (count == FULL_LVL);
    assign mic_data_valid = (state == ACTIVE) && (count != '0);
    assign pop            = mic_data_valid && mic_data_retrieved && !flush;
    assign do_push        = push_req && !flush && (!full || pop);
    assign push_drop      = push_req && !flush && full && !pop;

    // ---- Record control, packer and FIFO bookkeeping ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dly_cnt   <= '0;
            overflow  <= 1'b0;
            lin_q     <= 1'b0;
            chan_q    <= '0;
            pack_idx  <= '0;
            pack_sr   <= '0;
            push_req  <= 1'b0;
            push_word <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_next;
            if (record_start)        dly_cnt <= '0;
            else if (state == DELAY) dly_cnt <= dly_cnt + DW'(1);

            if (record_start && !record_stop) begin
                overflow <= 1'b0;
                lin_q    <= mode;
                chan_q   <= chan_sel;
            end else if (push_drop) begin
                overflow <= 1'b1;
            end

            if (flush) begin
                push_req <= 1'b0;
                pack_idx <= '0;
            end else if (enter_active) begin
                push_req  <= (PREFILL_SILENCE != 0);
                push_word <= lin_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
            end else if (frame_take) begin
                pack_sr <= packed_next;
                if (pack_last) begin
                    push_req  <= 1'b1;
                    push_word <= packed_next;
                    pack_idx  <= '0;
                end else begin
                    push_req  <= 1'b0;
                    pack_idx  <= pack_idx + 2'd1;
                end
            end else begin
                push_req <= 1'b0;
            end

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
                count <= count + LW'(do_push) - LW'(pop);
            end
        end
    end

    // ---- FIFO storage ----
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    assign mic_data   = (count != '0) ? mem[rd_ptr] : 32'h0000_0000;
    assign fifo_level = count;
    assign mic_debug  = {mic_data_valid, state == ACTIVE};

endmodule

// File: tb/tb_mic_capture_fifo.sv
module tb_mic_capture_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        record_start = 1'b0, record_stop = 1'b0;
    logic        bclk = 1'b0, lrck = 1'b1, audio_data_in = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  chan_sel = 2'd0;
    logic [31:0] mic_data;
    logic        mic_data_valid;
    logic        mic_data_retrieved = 1'b0;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [1:0]  mic_debug;

    always #5 clk = ~clk;

    mic_capture_fifo #(
        .SAMPLE_BITS(16), .FIFO_DEPTH(4), .START_DELAY(400), .PREFILL_SILENCE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .record_start(record_start), .record_stop(record_stop),
        .bclk(bclk), .lrck(lrck), .audio_data_in(audio_data_in), .mode(mode),
        .chan_sel(chan_sel), .mic_data(mic_data), .mic_data_valid(mic_data_valid),
        .mic_data_retrieved(mic_data_retrieved), .fifo_level(fifo_level),
        .overflow(overflow), .mic_debug(mic_debug)
    );

    typedef struct {
        logic             m;
        logic [1:0]       c;
        logic [3:0][15:0] l;
        logic [3:0][15:0] r;
        logic [31:0]      exp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[9];

    function automatic vec_t mk(input logic m, input logic [1:0] c,
                                input logic [15:0] l0, l1, l2, l3,
                                input logic [15:0] r0, r1, r2, r3,
                                input logic [31:0] exp);
        vec_t v;
        v.m = m; v.c = c; v.exp = exp;
        v.l[0] = l0; v.l[1] = l1; v.l[2] = l2; v.l[3] = l3;
        v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic lr, input logic d);
        lrck = lr;
        audio_data_in = d;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (4) @(negedge clk);
        bclk = 1'b0;
    endtask

    // 20 bit times per slot: delay bit, 16 data bits MSB first, 3 padding.
    task automatic send_slot(input logic lr, input logic [15:0] v);
        for (int b = 0; b < 20; b++)
            send_bit(lr, (b >= 1 && b <= 16) ? v[16-b] : 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l);
        send_slot(1'b1, r);
    endtask

    task automatic pulse_start(input logic m, input logic [1:0] c);
        mode = m;
        chan_sel = c;
        record_start = 1'b1;
        @(negedge clk);
        record_start = 1'b0;
    endtask

    task automatic pulse_stop();
        record_stop = 1'b1;
        @(negedge clk);
        record_stop = 1'b0;
    endtask

    task automatic pop();
        mic_data_retrieved = 1'b1;
        @(negedge clk);
        mic_data_retrieved = 1'b0;
    endtask

    task automatic wait_active();
        int k = 0;
        while (!mic_debug[0] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!mic_debug[0]) begin
            n_cmp++; n_err++;
            $display("FAIL wait_active: timeout, debug=%b", mic_debug);
        end
    endtask

    task automatic wait_level(input int n);
        int k = 0;
        while (int'(fifo_level) != n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (int'(fifo_level) != n) begin
            n_cmp++; n_err++;
            $display("FAIL wait_level: timeout, level=%0d, wanted %0d", fifo_level, n);
        end
    endtask

    initial begin
        vecs[0] = mk(1, 0, 16'h1234, 16'h5678, 0, 0, 16'hABCD, 16'h0000, 0, 0, 32'h12345678);
        vecs[1] = mk(1, 1, 16'h1234, 16'h5678, 0, 0, 16'hABCD, 16'h0000, 0, 0, 32'hABCD0000);
        vecs[2] = mk(1, 2, 16'h1000, 16'h8000, 0, 0, 16'h3000, 16'h7FFF, 0, 0, 32'h2000FFFF);
        vecs[3] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                     16'h1234, 16'h1234, 16'h1234, 16'h1234, 32'hFFFFFFFF);
        vecs[4] = mk(0, 0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 32'h80808080);
        vecs[5] = mk(0, 3, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00,
                     16'h5555, 16'h5555, 16'h5555, 16'h5555, 32'hE767E767);
        vecs[6] = mk(0, 1, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA,
                     16'h7FFF, 16'h0000, 16'h0100, 16'hFF00, 32'h80FFE767);
        vecs[7] = mk(1, 2, 16'h0003, 16'hFFFF, 0, 0, 16'h0001, 16'hFFFE, 0, 0, 32'h0002FFFE);
        vecs[8] = mk(0, 0, 16'h1000, 16'hF000, 16'h0020, 16'h0000, 0, 0, 0, 0, 32'hAF2FFBFF);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_level", fifo_level, 0);
        check("reset_valid", mic_data_valid, 0);
        check("reset_debug", mic_debug, 0);
        check("reset_ovf", overflow, 0);
        check("reset_data", mic_data, 0);
        rst_n = 1'b1;
        // Give the deframer a reference LRCK level before the first frame.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);

        // Linear left with silence prefill, level 1,2,1,0
        pulse_start(1'b1, 2'd0);
        wait_active();
        wait_level(1);
        check("t1_lvl1", fifo_level, 1);
        check("t1_prefill", mic_data, 32'h00000000);
        check("t1_valid", mic_data_valid, 1);
        send_frame(16'h1234, 16'hABCD);
        send_frame(16'h5678, 16'h0000);
        wait_level(2);
        check("t1_lvl2", fifo_level, 2);
        pop();
        check("t1_lvl_after_pop1", fifo_level, 1);
        check("t1_word", mic_data, 32'h12345678);
        pop();
        check("t1_lvl_after_pop2", fifo_level, 0);
        check("t1_valid_drop", mic_data_valid, 0);

        // Table of channel/encoding vectors; each restarts from ACTIVE.
        foreach (vecs[i]) begin
            pulse_start(vecs[i].m, vecs[i].c);
            check("vec_restart_lvl", fifo_level, 0);
            wait_active();
            wait_level(1);
            check("vec_prefill", mic_data, vecs[i].m ? 32'h00000000 : 32'hFFFFFFFF);
            pop();
            for (int f = 0; f < (vecs[i].m ? 2 : 4); f++)
                send_frame(vecs[i].l[f], vecs[i].r[f]);
            wait_level(1);
            check($sformatf("vec%0d_word", i), mic_data, vecs[i].exp);
            pop();
            check("vec_empty", mic_data_valid, 0);
        end

        // Overflow: prefill + five data words into a 4-deep FIFO
        pulse_start(1'b1, 2'd0);
        wait_active();
        wait_level(1);
        for (int f = 0; f < 10; f++) send_frame(16'(16'h1111 * (f + 1)), 16'h0000);
        repeat (10) @(negedge clk);
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_pop0", mic_data, 32'h00000000);
        pop();
        check("ovf_pop1", mic_data, 32'h11112222);
        pop();
        check("ovf_pop2", mic_data, 32'h33334444);
        pop();
        check("ovf_pop3", mic_data, 32'h55556666);
        pop();
        check("ovf_drained", fifo_level, 0);
        check("ovf_still_set", overflow, 1);
        pulse_start(1'b0, 2'd0);
        check("ovf_cleared", overflow, 0);

        // Stop mid-word: partial mu-law word must not leak into the next word
        wait_active();
        wait_level(1);
        send_frame(16'h0000, 16'h0000);
        send_frame(16'h0000, 16'h0000);
        pulse_stop();
        check("stop_valid", mic_data_valid, 0);
        check("stop_level", fifo_level, 0);
        check("stop_idle", mic_debug, 0);
        pulse_start(1'b0, 2'd0);
        wait_active();
        wait_level(1);
        pop();
        for (int f = 0; f < 4; f++) send_frame(16'h7FFF, 16'h0000);
        wait_level(1);
        check("stop_restart_word", mic_data, 32'h80808080);
        pop();

        // A frame delivered during DELAY is discarded
        pulse_stop();
        pulse_start(1'b1, 2'd0);
        send_frame(16'hDEAD, 16'h0000);
        check("delay_not_active", mic_debug[0], 0);
        wait_active();
        wait_level(1);
        pop();
        send_frame(16'hBEEF, 16'h0000);
        repeat (20) @(negedge clk);
        check("delay_no_leak", fifo_level, 0);
        send_frame(16'hCAFE, 16'h0000);
        wait_level(1);
        check("delay_word", mic_data, 32'hBEEFCAFE);
        pop();

        // Simultaneous start and stop returns to IDLE
        record_start = 1'b1;
        record_stop = 1'b1;
        @(negedge clk);
        record_start = 1'b0;
        record_stop = 1'b0;
        repeat (500) @(negedge clk);
        check("startstop_idle", mic_debug, 0);
        check("startstop_level", fifo_level, 0);

        // Asynchronous reset mid-slot, then clean recapture
        pulse_start(1'b1, 2'd0);
        wait_active();
        wait_level(1);
        fork
            send_frame(16'h1357, 16'h2468);
            begin
                repeat (100) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("arst_level", fifo_level, 0);
                check("arst_valid", mic_data_valid, 0);
                check("arst_debug", mic_debug, 0);
                check("arst_data", mic_data, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        pulse_start(1'b1, 2'd0);
        wait_active();
        wait_level(1);
        pop();
        send_frame(16'h0F0F, 16'h0000);
        send_frame(16'hF0F0, 16'h0000);
        wait_level(1);
        check("arst_recapture", mic_data, 32'h0F0FF0F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
